// File: rtl/inst_fetch.sv
// Instruction fetch: at most one bus read in flight; the instruction appears on inst_o one cycle after its ack.
// The PC is held except in delivery cycles. A hold parks an acked word in a one-entry buffer until release.
module inst_fetch #(
  parameter logic [31:0] INST_NOP       = 32'h00000013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        jump_flag_i,
  input  logic [2:0]  hold_flag_i,
  output logic        pc_stall_o,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        ack_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH, HOLD} state_t;

  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] buf_dat_q, buf_dat_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic        buf_vld_q, buf_vld_d;
  logic        err_q, err_d;

  logic hold_stall;
  logic bus_busy;
  logic timeout;
  logic dlv_wait;
  logic dlv_buf;

  assign hold_stall = (hold_flag_i >= 3'b010);
  assign bus_busy   = (state_q == WAIT) || (state_q == FLUSH);
  // counter holds the number of earlier busy cycles, so this fires on the TIMEOUT_CYCLES-th one
  assign timeout    = bus_busy && !ack_i && ((cnt_q + 32'd1) >= TMO_LIM);
  assign dlv_wait   = !rst && (state_q == WAIT) && ack_i && !jump_flag_i && !hold_stall;
  assign dlv_buf    = !rst && (state_q == HOLD) && buf_vld_q && !jump_flag_i && !hold_stall;

  assign pc_stall_o   = !(dlv_wait || dlv_buf);
  assign req_o        = bus_busy;
  assign addr_o       = addr_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = inst_valid_q;
  assign err_o        = err_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    buf_vld_d  = buf_vld_q;
    buf_dat_d  = buf_dat_q;
    buf_addr_d = buf_addr_q;

    case (state_q)
      IDLE: begin
        if (!jump_flag_i) begin
          addr_d  = pc_i;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (jump_flag_i) begin
          state_d = ack_i ? IDLE : FLUSH;
        end else if (ack_i) begin
          if (hold_stall) begin
            buf_vld_d  = 1'b1;
            buf_dat_d  = rdata_i;
            buf_addr_d = addr_q;
            state_d    = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (ack_i) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (jump_flag_i || !hold_stall) begin
          buf_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = 32'd0;
    end else if (bus_busy) begin
      cnt_d = cnt_q + 32'd1;
    end

    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = inst_valid_q;
    if (jump_flag_i) begin
      inst_d       = INST_NOP;
      inst_valid_d = 1'b0;
    end else if (dlv_wait) begin
      inst_d       = rdata_i;
      inst_addr_d  = addr_q;
      inst_valid_d = 1'b1;
    end else if (dlv_buf) begin
      inst_d       = buf_dat_q;
      inst_addr_d  = buf_addr_q;
      inst_valid_d = 1'b1;
    end else if (!hold_stall) begin
      inst_d       = INST_NOP;
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      cnt_q        <= 32'd0;
      inst_q       <= INST_NOP;
      inst_addr_q  <= 32'd0;
      inst_valid_q <= 1'b0;
      buf_vld_q    <= 1'b0;
      buf_dat_q    <= 32'd0;
      buf_addr_q   <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
      buf_vld_q    <= buf_vld_d;
      buf_dat_q    <= buf_dat_d;
      buf_addr_q   <= buf_addr_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a scoreboard of expected deliveries plus cycle-exact checks
// of reset, hold, flush, jump-with-ack, timeout and reset-during-request behaviour.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        jump_flag_i;
  logic [2:0]  hold_flag_i;
  logic        pc_stall_o;
  logic        req_o;
  logic [31:0] addr_o;
  logic        ack_i;
  logic [31:0] rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        err_o;

  int checks   = 0;
  int errors   = 0;
  int bad_seen = 0;
  int req_cnt;
  logic        dlv_pend = 1'b0;
  logic [63:0] sb_q[$];
  logic [63:0] sb_e;
  logic [31:0] snap_inst;
  logic [31:0] snap_iaddr;
  logic        snap_vld;

  always #5 clk = ~clk;

  inst_fetch #(.INST_NOP(NOP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .jump_flag_i  (jump_flag_i),
    .hold_flag_i  (hold_flag_i),
    .pc_stall_o   (pc_stall_o),
    .req_o        (req_o),
    .addr_o       (addr_o),
    .ack_i        (ack_i),
    .rdata_i      (rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // a delivery cycle (pc_stall_o low) must put the next scoreboard entry on the outputs one cycle later
  always @(negedge clk) begin
    if (dlv_pend) begin
      if (sb_q.size() == 0) begin
        chk("sb_depth", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_inst", inst_o, sb_e[31:0]);
        chk("sb_addr", inst_addr_o, sb_e[63:32]);
        chk("sb_vld", 32'(inst_valid_o), 32'd1);
      end
    end
    dlv_pend = !pc_stall_o && !rst;
    if (inst_o == 32'hDEADBEEF || inst_o == 32'hCAFEF00D ||
        inst_o == 32'h11111111 || inst_o == 32'h12345678)
      bad_seen++;
  end

  initial begin
    rst = 1'b1; pc_i = 32'h0; jump_flag_i = 1'b0; hold_flag_i = 3'b000;
    ack_i = 1'b0; rdata_i = 32'h0;
    tick(); tick();
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_iaddr", inst_addr_o, 32'h0);
    chk("rst_vld", 32'(inst_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_req", 32'(req_o), 32'd0);

    // basic fetch, ack in the third WAIT cycle
    rst = 1'b0;
    tick();
    req_cnt = 0;
    repeat (2) begin
      if (req_o) req_cnt++;
      chk("s1_stall_wait", 32'(pc_stall_o), 32'd1);
      tick();
    end
    ack_i = 1'b1; rdata_i = 32'h00500093;
    sb_q.push_back({32'h0, 32'h00500093});
    #1;
    if (req_o) req_cnt++;
    chk("s1_addr", addr_o, 32'h0);
    chk("s1_stall_ack", 32'(pc_stall_o), 32'd0);
    tick();
    ack_i = 1'b0; pc_i = 32'h4;
    chk("s1_req_cycles", 32'(req_cnt), 32'd3);
    chk("s1_inst", inst_o, 32'h00500093);
    chk("s1_vld", 32'(inst_valid_o), 32'd1);
    chk("s1_iaddr", inst_addr_o, 32'h0);
    #1;
    chk("s1_stall_after", 32'(pc_stall_o), 32'd1);
    chk("s1_req_idle", 32'(req_o), 32'd0);

    // ack under hold parks the word; stray acks while parked are ignored
    tick();
    chk("s2_addr", addr_o, 32'h4);
    snap_inst = inst_o; snap_iaddr = inst_addr_o; snap_vld = inst_valid_o;
    ack_i = 1'b1; rdata_i = 32'h00A00113; hold_flag_i = 3'b011;
    sb_q.push_back({32'h4, 32'h00A00113});
    #1 chk("s2_stall_ack", 32'(pc_stall_o), 32'd1);
    tick();
    rdata_i = 32'h11111111;
    repeat (3) begin
      #1;
      chk("s2_hold_req", 32'(req_o), 32'd0);
      chk("s2_hold_stall", 32'(pc_stall_o), 32'd1);
      chk("s2_hold_inst", inst_o, snap_inst);
      chk("s2_hold_iaddr", inst_addr_o, snap_iaddr);
      chk("s2_hold_vld", 32'(inst_valid_o), 32'(snap_vld));
      tick();
    end
    ack_i = 1'b0; hold_flag_i = 3'b000;
    #1 chk("s2_stall_release", 32'(pc_stall_o), 32'd0);
    tick();
    pc_i = 32'h8;
    chk("s2_inst", inst_o, 32'h00A00113);
    chk("s2_iaddr", inst_addr_o, 32'h4);
    chk("s2_vld", 32'(inst_valid_o), 32'd1);

    // jump while waiting: flush, drop the late data, refetch from the target
    tick();
    chk("s3_addr", addr_o, 32'h8);
    tick();
    jump_flag_i = 1'b1;
    #1 chk("s3_stall_jump", 32'(pc_stall_o), 32'd1);
    tick();
    jump_flag_i = 1'b0; pc_i = 32'h100;
    chk("s3_flush_req", 32'(req_o), 32'd1);
    chk("s3_flush_addr", addr_o, 32'h8);
    chk("s3_flush_vld", 32'(inst_valid_o), 32'd0);
    chk("s3_flush_inst", inst_o, NOP);
    tick();
    jump_flag_i = 1'b1;
    tick();
    jump_flag_i = 1'b0;
    chk("s3_flush_again", 32'(req_o), 32'd1);
    chk("s3_flush_addr2", addr_o, 32'h8);
    ack_i = 1'b1; rdata_i = 32'hDEADBEEF;
    #1 chk("s3_stall_flush_ack", 32'(pc_stall_o), 32'd1);
    tick();
    ack_i = 1'b0;
    chk("s3_idle_req", 32'(req_o), 32'd0);
    chk("s3_idle_vld", 32'(inst_valid_o), 32'd0);
    tick();
    chk("s3_new_addr", addr_o, 32'h100);
    chk("s3_new_req", 32'(req_o), 32'd1);
    ack_i = 1'b1; rdata_i = 32'h00108093;
    sb_q.push_back({32'h100, 32'h00108093});
    tick();
    ack_i = 1'b0; pc_i = 32'h104;
    chk("s3_inst", inst_o, 32'h00108093);

    // jump and ack in the same cycle: data dropped
    tick();
    chk("s4_addr", addr_o, 32'h104);
    ack_i = 1'b1; jump_flag_i = 1'b1; rdata_i = 32'hCAFEF00D;
    #1 chk("s4_stall", 32'(pc_stall_o), 32'd1);
    tick();
    ack_i = 1'b0; jump_flag_i = 1'b0; pc_i = 32'h200;
    chk("s4_req", 32'(req_o), 32'd0);
    chk("s4_vld", 32'(inst_valid_o), 32'd0);
    chk("s4_inst", inst_o, NOP);
    tick();
    chk("s4_new_addr", addr_o, 32'h200);
    chk("s4_new_req", 32'(req_o), 32'd1);

    // no ack: bus timeout after TMO request cycles, same address reissued
    req_cnt = 0;
    for (int i = 0; i < 400 && !err_o; i++) begin
      if (req_o) req_cnt++;
      tick();
    end
    chk("s5_err_seen", 32'(err_o), 32'd1);
    chk("s5_req_cycles", 32'(req_cnt), 32'(TMO));
    chk("s5_req_drop", 32'(req_o), 32'd0);
    chk("s5_stall", 32'(pc_stall_o), 32'd1);
    tick();
    chk("s5_err_pulse", 32'(err_o), 32'd0);
    chk("s5_reissue_req", 32'(req_o), 32'd1);
    chk("s5_reissue_addr", addr_o, 32'h200);

    // reset mid-request, ack arriving during and after reset is ignored
    rst = 1'b1; ack_i = 1'b1; rdata_i = 32'h12345678;
    #1 chk("s6_stall_rst", 32'(pc_stall_o), 32'd1);
    tick();
    chk("s6_addr", addr_o, 32'h0);
    chk("s6_iaddr", inst_addr_o, 32'h0);
    chk("s6_req", 32'(req_o), 32'd0);
    chk("s6_vld", 32'(inst_valid_o), 32'd0);
    chk("s6_inst", inst_o, NOP);
    rst = 1'b0;
    #1 chk("s6_stall_late_ack", 32'(pc_stall_o), 32'd1);
    tick();
    ack_i = 1'b0;
    chk("s6_vld_after", 32'(inst_valid_o), 32'd0);
    chk("s6_inst_after", inst_o, NOP);
    chk("s6_iaddr_after", inst_addr_o, 32'h0);
    chk("s6_err_after", 32'(err_o), 32'd0);
    tick(); tick();

    chk("sb_left", 32'(sb_q.size()), 32'd0);
    chk("discarded_seen", 32'(bad_seen), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
